matmul_load_sequencer: RTL
==========================

Name: matmul_load_sequencer

Overview:
- Host-side controller that drives the loader's serial byte interface (`ctrl_logic`/`data_send`) for one matrix-multiply job at a time.
- Accepts a job descriptor (R1, C1, R2, C2) and a valid/ready element stream.
- Emits the loader framing: 4 dimension beats, R1*C1+R2*C2 element beats, 1 end beat.
- Then holds off until the multiplier reports completion, a timeout fires, or the job is aborted.

Parameters:
- DATA_W, 8: width of `data_send`, element data and dimension fields.
- MAX_DIM, 4: largest legal row/column count.
- TIMEOUT, 255: max cycles waited for `mult_done` before giving up (1..65535).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST_N  in  1  reset, asynchronous, active-low.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  sequencer can accept a job.
- r1, c1, r2, c2  in  DATA_W each  matrix dimensions; sampled on job handshake.
- elem_valid  in  1  element byte valid.
- elem_ready  out  1  sequencer will consume the element this cycle.
- elem_data  in  DATA_W  element byte; A row-major first, then B row-major.
- mult_done  in  1  multiplier finished the current job (pulse).
- abort  in  1  synchronous job abort.
- ctrl_logic  out  2  loader control: 0=element, 1=dimension, 2=end/compute, 3=idle.
- data_send  out  DATA_W  loader data byte.
- busy  out  1  state != IDLE.
- err  out  1  1-cycle pulse: job rejected for bad dimensions.
- timeout  out  1  1-cycle pulse: `mult_done` not seen within TIMEOUT.
- jobs_done  out  16  count of completed jobs; wraps at 65535 to 0.

Behaviour:
- Reset (RST_N low, async):
  - State IDLE.
  - `ctrl_logic`=3, `data_send`=0.
  - `err`=0, `timeout`=0, `jobs_done`=0, `busy`=0.
  - `elem_ready`=0, `job_ready`=1 once reset is released.
- Output registers: `ctrl_logic` and `data_send` are registered. A beat decided in cycle N appears after posedge N+1.
- `job_ready` = (state==IDLE) and abort==0. `elem_ready` = (state==DATA) and remaining>0 and abort==0. Both are combinational from state.
- Validation in IDLE on a job handshake:
  - Legal when every dimension is in 1..MAX_DIM and c1==r2.
  - Illegal: `err` pulses next cycle, state stays IDLE, no loader beat is emitted.
- DIMS (4 cycles): `ctrl_logic`=1 with `data_send` = r1, c1, r2, c2 on consecutive cycles. Load remaining = r1*c1 + r2*c2 (computed at DATA_W+1 bits, max 2*MAX_DIM^2).
- DATA:
  - Each element handshake emits `ctrl_logic`=0 with `data_send`=elem_data and decrements remaining.
  - A cycle without a handshake emits `ctrl_logic`=3, `data_send`=0. The loader ignores these; gaps are legal.
  - When remaining reaches 0, go to END.
- END (1 cycle): `ctrl_logic`=2, `data_send`=0. Then go to WAIT and clear the wait counter.
- WAIT:
  - `ctrl_logic`=3; the wait counter increments each cycle.
  - `mult_done` → IDLE, `jobs_done`+1.
  - Counter reaches TIMEOUT → `timeout` pulse, IDLE, `jobs_done` unchanged.
  - `mult_done` in the same cycle the counter reaches TIMEOUT: done wins, no timeout pulse.
- `mult_done` outside WAIT is ignored.
- abort:
  - In DIMS or DATA: emit one `ctrl_logic`=2 beat to close the loader frame, then go to IDLE. `jobs_done` unchanged, no error pulse.
  - In WAIT: go to IDLE immediately.
  - In IDLE: no effect; the job handshake is blocked that cycle.
- Back-to-back jobs: a job may be accepted in the first IDLE cycle after WAIT exits. No bubble beyond that one IDLE cycle.
- Reset asserted mid-job: immediate return to reset values. No end beat is emitted; the loader is reset by the same RST_N.

Test Plan:
- Legal 2x2 job: r1=c1=r2=c2=2, elements 1..8 streamed with no gaps, `mult_done` 5 cycles after END.
  → `ctrl_logic` sequence 1,1,1,1, 0×8, 2, then 3s; `data_send` 2,2,2,2,1..8,0; `jobs_done`=1.
- Illegal dimensions: r1=2, c1=3, r2=2, c2=2 (c1!=r2); separately r1=0 and r1=MAX_DIM+1.
  → `err` pulses 1 cycle each time; `ctrl_logic` stays 3; `busy` stays 0.
- Element gaps: 2x2 job, `elem_valid` toggled 1,0,0,1,... .
  → exactly 8 element beats, `ctrl_logic`=3 in gap cycles, element order preserved, END after the 8th element.
- Timeout: TIMEOUT=10, `mult_done` withheld.
  → `timeout` pulses 10 cycles after END, `jobs_done` unchanged.
  → Rerun with `mult_done` asserted on the 10th cycle: no timeout pulse, `jobs_done`+1.
- Abort mid-DATA after 3 elements.
  → next beat `ctrl_logic`=2, then IDLE.
  → `elem_ready` low from the abort cycle.
  → a following 3x3 * 3x1 job completes with 12 element beats.
- Reset mid-DATA, then three back-to-back 2x2 jobs.
  → outputs return to reset values asynchronously, `jobs_done`=0.
  → subsequent jobs complete with `jobs_done`=3 and a one-cycle IDLE between them.

Source files
------------

// File: rtl/matmul_load_sequencer.sv
// Host-side sequencer that frames one matrix-multiply job onto the loader's serial byte port:
// four dimension beats, the element stream, one end beat, then waits for the multiplier.
module matmul_load_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_DIM = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [DATA_W-1:0] r1,
    input  logic [DATA_W-1:0] c1,
    input  logic [DATA_W-1:0] r2,
    input  logic [DATA_W-1:0] c2,
    input  logic              elem_valid,
    output logic              elem_ready,
    input  logic [DATA_W-1:0] elem_data,
    input  logic              mult_done,
    input  logic              abort,
    output logic [1:0]        ctrl_logic,
    output logic [DATA_W-1:0] data_send,
    output logic              busy,
    output logic              err,
    output logic              timeout,
    output logic [15:0]       jobs_done
);

    localparam int unsigned REM_W = DATA_W + 1;
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    localparam logic [1:0] CTRL_ELEM = 2'd0;
    localparam logic [1:0] CTRL_DIM  = 2'd1;
    localparam logic [1:0] CTRL_END  = 2'd2;
    localparam logic [1:0] CTRL_IDLE = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StDims,
        StData,
        StEnd,
        StWait
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   r1_q;
    logic [DATA_W-1:0]   c1_q;
    logic [DATA_W-1:0]   r2_q;
    logic [DATA_W-1:0]   c2_q;
    logic [1:0]          dim_idx_q;
    logic [REM_W-1:0]    remaining_q;
    logic [15:0]         wait_cnt_q;

    logic                job_fire;
    logic                elem_fire;
    logic                dims_legal;
    logic                wait_hit;
    logic [DATA_W-1:0]   dim_sel;
    logic [2*DATA_W-1:0] prod_a;
    logic [2*DATA_W-1:0] prod_b;
    logic [REM_W-1:0]    rem_load;

    function automatic logic dim_ok(input logic [DATA_W-1:0] d);
        return (d != '0) && (32'(d) <= MAX_DIM);
    endfunction

    assign job_ready  = (state_q == StIdle) && !abort;
    assign elem_ready = (state_q == StData) && (remaining_q != '0) && !abort;
    assign busy       = (state_q != StIdle);

    assign job_fire   = job_valid && job_ready;
    assign elem_fire  = elem_valid && elem_ready;
    assign dims_legal = dim_ok(r1) && dim_ok(c1) && dim_ok(r2) && dim_ok(c2) && (c1 == r2);

    // Dimensions are bounded by MAX_DIM, so the element count fits in DATA_W+1 bits.
    assign prod_a   = r1_q * c1_q;
    assign prod_b   = r2_q * c2_q;
    assign rem_load = prod_a[REM_W-1:0] + prod_b[REM_W-1:0];

    assign wait_hit = (wait_cnt_q + 16'd1) == TIMEOUT_W;

    always_comb begin
        dim_sel = r1_q;
        unique case (dim_idx_q)
            2'd0: dim_sel = r1_q;
            2'd1: dim_sel = c1_q;
            2'd2: dim_sel = r2_q;
            2'd3: dim_sel = c2_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            r1_q        <= '0;
            c1_q        <= '0;
            r2_q        <= '0;
            c2_q        <= '0;
            dim_idx_q   <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            ctrl_logic  <= CTRL_IDLE;
            data_send   <= '0;
            err         <= 1'b0;
            timeout     <= 1'b0;
            jobs_done   <= '0;
        end else begin
            ctrl_logic <= CTRL_IDLE;
            data_send  <= '0;
            err        <= 1'b0;
            timeout    <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (job_fire) begin
                        r1_q <= r1;
                        c1_q <= c1;
                        r2_q <= r2;
                        c2_q <= c2;
                        if (dims_legal) begin
                            state_q   <= StDims;
                            dim_idx_q <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                StDims: begin
                    if (abort) begin
                        ctrl_logic <= CTRL_END;
                        state_q    <= StIdle;
                    end else begin
                        ctrl_logic <= CTRL_DIM;
                        data_send  <= dim_sel;
                        dim_idx_q  <= dim_idx_q + 2'd1;
                        if (dim_idx_q == 2'd3) begin
                            state_q     <= StData;
                            remaining_q <= rem_load;
                        end
                    end
                end

                StData: begin
                    if (abort) begin
                        // Close the loader frame so it does not wait for missing elements.
                        ctrl_logic <= CTRL_END;
                        state_q    <= StIdle;
                    end else if (elem_fire) begin
                        ctrl_logic  <= CTRL_ELEM;
                        data_send   <= elem_data;
                        remaining_q <= remaining_q - REM_W'(1);
                        if (remaining_q == REM_W'(1)) begin
                            state_q <= StEnd;
                        end
                    end
                end

                StEnd: begin
                    ctrl_logic <= CTRL_END;
                    wait_cnt_q <= '0;
                    state_q    <= abort ? StIdle : StWait;
                end

                StWait: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (mult_done) begin
                        // Completion takes priority over a timeout landing in the same cycle.
                        state_q   <= StIdle;
                        jobs_done <= jobs_done + 16'd1;
                    end else if (wait_hit) begin
                        timeout <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
